// File: rtl/bitwise_slice_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bitwise_slice_unit                                                          |
// | Multicycle AND/OR/XOR/ANDN unit, SLICE bits per cycle, valid/ready I/O.     |
// | Optional: BITWISE_SLICE_REDUCE_EN adds registered red_and/red_or/red_xor.   |
// | Revision: 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module bitwise_slice_unit #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero
`ifdef BITWISE_SLICE_REDUCE_EN
   ,
   output logic             red_and,
   output logic             red_or,
   output logic             red_xor
`endif
);

   localparam int c_nslice = WIDTH / SLICE;
   localparam int c_cw     = (c_nslice > 1) ? $clog2(c_nslice) : 1;
   localparam logic [c_cw-1:0] c_last = c_cw'(c_nslice - 1);

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_busy = 2'd1;
   localparam logic [1:0] c_done = 2'd2;

   generate
      if ((WIDTH % SLICE) != 0) begin : g_bad_slice
         $error("bitwise_slice_unit: SLICE must divide WIDTH exactly");
      end
   endgenerate

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [c_cw-1:0]  r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [1:0]       r_op;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic [SLICE-1:0] w_sl_a;
   logic [SLICE-1:0] w_sl_b;
   logic [SLICE-1:0] w_sl_res;
   logic [WIDTH-1:0] w_next;
   logic             w_last;

   assign w_last = (r_cnt == c_last);

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= c_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_idle:  if (in_valid) w_state_nxt = c_busy;
         c_busy:  if (w_last) w_state_nxt = c_done;
         c_done:  if (out_ready) w_state_nxt = c_idle;
         default: w_state_nxt = c_idle;
      endcase
   end

   // Handshake outputs
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         c_idle:  in_ready  = 1'b1;
         c_done:  out_valid = 1'b1;
         default: ;
      endcase
   end

   // Only the slice selected by the counter is computed each cycle
   always_comb begin
      w_sl_a = '0;
      w_sl_b = '0;
      for (int i = 0; i < c_nslice; i++) begin
         if (int'(r_cnt) == i) begin
            w_sl_a = r_a[i*SLICE +: SLICE];
            w_sl_b = r_b[i*SLICE +: SLICE];
         end
      end
      case (r_op)
         2'b01:   w_sl_res = w_sl_a | w_sl_b;
         2'b10:   w_sl_res = w_sl_a ^ w_sl_b;
         2'b11:   w_sl_res = w_sl_a & ~w_sl_b;
         default: w_sl_res = w_sl_a & w_sl_b;
      endcase
      w_next = r_result;
      for (int i = 0; i < c_nslice; i++) begin
         if (int'(r_cnt) == i) begin
            w_next[i*SLICE +: SLICE] = w_sl_res;
         end
      end
   end

`ifdef BITWISE_SLICE_REDUCE_EN
   logic r_red_and;
   logic r_red_or;
   logic r_red_xor;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_op     <= 2'b00;
         r_result <= '0;
         r_zero   <= 1'b0;
`ifdef BITWISE_SLICE_REDUCE_EN
         r_red_and <= 1'b0;
         r_red_or  <= 1'b0;
         r_red_xor <= 1'b0;
`endif
      end else begin
         case (r_state)
            c_idle: begin
               if (in_valid) begin
                  r_a      <= a;
                  r_b      <= b;
                  r_op     <= op;
                  r_cnt    <= '0;
                  r_result <= '0;
                  r_zero   <= 1'b0;
`ifdef BITWISE_SLICE_REDUCE_EN
                  r_red_and <= 1'b0;
                  r_red_or  <= 1'b0;
                  r_red_xor <= 1'b0;
`endif
               end
            end
            c_busy: begin
               r_result <= w_next;
               r_cnt    <= r_cnt + c_cw'(1);
               // Flags see the complete result including the slice written now
               if (w_last) begin
                  r_zero <= ~|w_next;
`ifdef BITWISE_SLICE_REDUCE_EN
                  r_red_and <= &w_next;
                  r_red_or  <= |w_next;
                  r_red_xor <= ^w_next;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign result = r_result;
   assign zero   = r_zero;
`ifdef BITWISE_SLICE_REDUCE_EN
   assign red_and = r_red_and;
   assign red_or  = r_red_or;
   assign red_xor = r_red_xor;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bitwise_slice_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bitwise_slice_unit                                                       |
// | Directed vectors for bitwise_slice_unit at 32/8 and 16/16 configurations.  |
// | Revision: 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_bitwise_slice_unit;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        z;
      logic        rand_;
      logic        ror;
      logic        rxor;
      int          bp;
   } vec_t;

   logic        clock;
   logic        reset_n;
   logic        in_valid, in_ready, out_valid, out_ready, zero;
   logic [1:0]  op;
   logic [31:0] a, b, result;
   logic        in_valid16, in_ready16, out_valid16, out_ready16, zero16;
   logic [1:0]  op16;
   logic [15:0] a16, b16, result16;
`ifdef BITWISE_SLICE_REDUCE_EN
   logic        red_and, red_or, red_xor;
   logic        red_and16, red_or16, red_xor16;
`endif

   int n_cmp  = 0;
   int n_fail = 0;
   vec_t vecs[7];

   bitwise_slice_unit #(.WIDTH(32), .SLICE(8)) u_dut (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero)
`ifdef BITWISE_SLICE_REDUCE_EN
      , .red_and(red_and), .red_or(red_or), .red_xor(red_xor)
`endif
   );

   bitwise_slice_unit #(.WIDTH(16), .SLICE(16)) u_dut16 (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid16), .in_ready(in_ready16), .op(op16), .a(a16), .b(b16),
      .out_valid(out_valid16), .out_ready(out_ready16), .result(result16), .zero(zero16)
`ifdef BITWISE_SLICE_REDUCE_EN
      , .red_and(red_and16), .red_or(red_or16), .red_xor(red_xor16)
`endif
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic run32(input vec_t v);
      int lat;
      logic [31:0] hold_res;
      logic        hold_z;
      lat = 0;
      chk("idle_in_ready", {31'b0, in_ready}, 32'd1);
      in_valid = 1'b1; op = v.op; a = v.a; b = v.b; out_ready = 1'b0;
      tick();
      // Captured operands must be used, not the live inputs
      in_valid = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
      chk("busy_in_ready", {31'b0, in_ready}, 32'd0);
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk("latency", lat, 32'd4);
      chk("result", result, v.res);
      chk("zero", {31'b0, zero}, {31'b0, v.z});
`ifdef BITWISE_SLICE_REDUCE_EN
      chk("red_and", {31'b0, red_and}, {31'b0, v.rand_});
      chk("red_or", {31'b0, red_or}, {31'b0, v.ror});
      chk("red_xor", {31'b0, red_xor}, {31'b0, v.rxor});
`endif
      if (v.bp > 0) begin
         hold_res = result;
         hold_z   = zero;
         in_valid = 1'b1; op = 2'b01; a = 32'h8000_0000; b = 32'h0000_0001;
         repeat (v.bp) begin
            tick();
            chk("bp_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_result", result, v.res);
            chk("bp_zero", {31'b0, zero}, {31'b0, hold_z});
         end
         chk("bp_hold", result, hold_res);
      end
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      chk("consumed_valid", {31'b0, out_valid}, 32'd0);
      chk("consumed_in_ready", {31'b0, in_ready}, 32'd1);
      tick();
      chk("not_accepted", {31'b0, in_ready}, 32'd1);
   endtask

   task automatic run16(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] er, input logic ez, input logic [2:0] ered);
      int lat;
      lat = 0;
      in_valid16 = 1'b1; op16 = o; a16 = x; b16 = y;
      tick();
      in_valid16 = 1'b0; a16 = 16'h5A5A; b16 = 16'hA5A5; op16 = ~o;
      while (!out_valid16 && lat < 20) begin
         tick();
         lat++;
      end
      chk("w16_latency", lat, 32'd1);
      chk("w16_result", {16'b0, result16}, {16'b0, er});
      chk("w16_zero", {31'b0, zero16}, {31'b0, ez});
`ifdef BITWISE_SLICE_REDUCE_EN
      chk("w16_red", {29'b0, red_and16, red_or16, red_xor16}, {29'b0, ered});
`endif
      out_ready16 = 1'b1;
      tick();
      out_ready16 = 1'b0;
      chk("w16_consumed", {31'b0, out_valid16}, 32'd0);
      chk("w16_in_ready", {31'b0, in_ready16}, 32'd1);
   endtask

   initial begin
      int seen;
      //           op     a             b             result        z  and or xor bp
      vecs[0] = '{2'b00, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 0, 0, 1, 0, 0};
      vecs[1] = '{2'b10, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 1, 0, 0, 0, 3};
      vecs[2] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'hFFFF_0000, 0, 0, 1, 0, 3};
      vecs[3] = '{2'b01, 32'h8000_0000, 32'h0000_0001, 32'h8000_0001, 0, 0, 1, 0, 0};
      vecs[4] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 1, 0, 0};
      vecs[5] = '{2'b11, 32'h0000_000F, 32'h0000_0008, 32'h0000_0007, 0, 0, 1, 1, 0};
      vecs[6] = '{2'b10, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'hAAAA_AAAA, 0, 0, 1, 0, 0};

      reset_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; op = 2'b00; a = '0; b = '0;
      in_valid16 = 1'b0; out_ready16 = 1'b0; op16 = 2'b00; a16 = '0; b16 = '0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_result", result, 32'h0);
      chk("rst_zero", {31'b0, zero}, 32'd0);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
`ifdef BITWISE_SLICE_REDUCE_EN
      chk("rst_red", {29'b0, red_and, red_or, red_xor}, 32'd0);
`endif
      reset_n = 1'b1;
      tick();

      for (int i = 0; i < 7; i++) begin
         run32(vecs[i]);
      end

      // Reset in the middle of BUSY discards the request
      in_valid = 1'b1; op = 2'b00; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      chk("busy_partial", result, 32'h0000_FFFF);
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrst_result", result, 32'h0);
      chk("midrst_zero", {31'b0, zero}, 32'd0);
      chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      seen = 0;
      repeat (10) begin
         tick();
         if (out_valid) seen++;
      end
      chk("midrst_no_output", seen, 32'd0);
      chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);

      run16(2'b00, 16'h1234, 16'h00FF, 16'h0034, 1'b0, 3'b011);
      run16(2'b10, 16'hBEEF, 16'hBEEF, 16'h0000, 1'b1, 3'b000);
      run16(2'b11, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 3'b110);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
